mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- DRP master that reprograms a Xilinx 7-series MMCM/PLL at run time, the initiator side of the DRP port that the clock-generation block currently ties off.
- Accepts a burst of masked register writes over a valid/ready command stream and holds the MMCM in reset while it writes.
- Performs a read-modify-write for each register, releases reset, then supervises relock with timeouts.
- Sits in the housekeeping domain on the DRP clock, next to the clock-generation block.

Parameters:
DRP_TIMEOUT, 64, max cycles to wait for drp_rdy after a drp_en strobe
RST_HOLD, 8, cycles mmcm_rst stays high after the last write completes
LOCK_TIMEOUT, 1000000, max cycles to wait for lock after mmcm_rst deasserts

Ports:
clk  in  1  DRP clock, also drives the MMCM DCLK
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  7  DRP register address
cmd_data  in  16  new bit values
cmd_mask  in  16  1 = preserve the existing bit, 0 = take the cmd_data bit
cmd_last  in  1  final command of the burst
drp_addr  out  7  to MMCM DADDR
drp_en  out  1  to MMCM DEN, one-cycle strobe
drp_we  out  1  to MMCM DWE
drp_di  out  16  to MMCM DI
drp_do  in  16  from MMCM DO
drp_rdy  in  1  from MMCM DRDY
mmcm_rst  out  1  to MMCM RST
mmcm_locked  in  1  MMCM LOCKED, asynchronous; 2-flop synchronized internally
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
err_code  out  2  0 = ok, 1 = DRP timeout, 2 = lock timeout; held until the next sequence starts

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE. All outputs 0 except cmd_ready=1. Counters and synchronizer flops cleared. Reset mid-sequence aborts immediately with no cleanup; mmcm_rst drops to 0.
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, ACCEPT, DRAIN, HOLD, LOCK_WAIT.
- cmd_ready is 1 only in IDLE, ACCEPT and DRAIN. The accepted command (addr/data/mask/last) is registered on the handshake.
- IDLE: on a handshake, clear err_code, set busy=1 and mmcm_rst=1 from the next cycle, go to RD.
- RD: drp_en=1, drp_we=0, drp_addr=cmd_addr for exactly one cycle, then RD_WAIT.
- RD_WAIT: the wait counter starts the cycle after the strobe. On drp_rdy, capture drp_do and go to WR. drp_rdy in the strobe cycle itself is ignored. If the counter reaches DRP_TIMEOUT, set err_code=1 and go to DRAIN (or HOLD if last).
- WR: drp_en=1, drp_we=1, drp_di=(captured_do & mask) | (data & ~mask) for one cycle, then WR_WAIT.
- WR_WAIT: on drp_rdy, go to HOLD if last, else ACCEPT. Timeout handling is identical to RD_WAIT.
- ACCEPT: wait for a handshake, then RD. Gaps in cmd_valid are allowed; mmcm_rst stays high throughout.
- DRAIN: accept and discard commands until one with cmd_last is accepted, then HOLD.
- HOLD: mmcm_rst stays 1 for RST_HOLD cycles, then deasserts and the state goes to LOCK_WAIT.
- LOCK_WAIT: count from the first cycle after mmcm_rst falls.
  - Synchronized lock=1: done pulse, then IDLE.
  - Counter reaches LOCK_TIMEOUT: if err_code==0 set it to 2, done pulse, then IDLE.
  - An earlier err_code=1 is never overwritten.
- busy clears in the same cycle done pulses.
- drp_en is never high in two consecutive cycles, and never high outside RD/WR.
- Counter widths: $clog2(parameter+1). The lock path adds 2 cycles of synchronizer latency.

Test Plan:
1. Single command {addr 0x08, data 0x1041, mask 0xE000, last=1}; DRP model returns DO=0xA5A5 with DRDY 3 cycles after DEN; lock asserted 10 cycles after mmcm_rst falls -> read strobe on 0x08, then write strobe with DI=0xB041, mmcm_rst high RST_HOLD cycles after the write DRDY, done pulse about 12 cycles after release, err_code=0.
2. Three-command burst (addrs 0x08, 0x09, 0x14) with 5-cycle cmd_valid gaps -> DRP accesses in that order, mmcm_rst continuously high from the first RD until HOLD expires, cmd_ready=0 during every RD/WR/wait state.
3. DRP model withholds DRDY on the second command's read, DRP_TIMEOUT=64 -> err_code=1 64 cycles after the strobe, third command drained with no DEN, lock wait proceeds, done pulses, err_code remains 1.
4. LOCK_TIMEOUT=100, mmcm_locked held 0 -> done exactly 100 cycles after mmcm_rst falls, err_code=2, busy=0.
5. rstn pulsed low during WR_WAIT -> mmcm_rst, drp_en, busy go to 0 asynchronously. After release cmd_ready=1 and a fresh single-command sequence completes with err_code=0.
6. cmd_valid held high during LOCK_WAIT -> no handshake until the done pulse; the command is accepted in the first IDLE cycle afterwards and err_code clears.

Source files
------------

// File: rtl/mmcm_drp_reconfig.sv
// DRP master for run-time MMCM/PLL reprogramming.
// Masked read-modify-write bursts, MMCM reset hold and relock supervision.
module mmcm_drp_reconfig #(
  parameter int DRP_TIMEOUT  = 64,
  parameter int RST_HOLD     = 8,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  input  logic        cmd_last,
  output logic [6:0]  drp_addr,
  output logic        drp_en,
  output logic        drp_we,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code
);

  localparam int WW = $clog2(DRP_TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WW-1:0] W_LIM = WW'(DRP_TIMEOUT - 1);
  localparam logic [HW-1:0] H_LIM = HW'(RST_HOLD - 1);
  localparam logic [LW-1:0] L_LIM = LW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT,
    ACCEPT, DRAIN, HOLD, LOCK_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [6:0]    addr_q;
  logic [15:0]   data_q;
  logic [15:0]   mask_q;
  logic          last_q;
  logic [15:0]   rdat_q;
  logic [WW-1:0] wcnt_q;
  logic [HW-1:0] hcnt_q;
  logic [LW-1:0] lcnt_q;
  logic [1:0]    sync_q;

  logic hs, in_wait, drp_to, hold_end;
  logic lock_ok, lock_to, fin;

  always_comb begin
    cmd_ready = (state_q == IDLE) || (state_q == ACCEPT) ||
                (state_q == DRAIN);
    hs        = cmd_valid && cmd_ready;
    in_wait   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    drp_to    = (wcnt_q == W_LIM);
    hold_end  = (hcnt_q == H_LIM);
    lock_ok   = sync_q[1];
    lock_to   = (lcnt_q == L_LIM);
    fin       = (state_q == LOCK_WAIT) && (lock_ok || lock_to);
    drp_en    = (state_q == RD) || (state_q == WR);
    drp_we    = (state_q == WR);
    drp_addr  = addr_q;
    drp_di    = '0;
    if (state_q == WR)
      drp_di = (rdat_q & mask_q) | (data_q & ~mask_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (hs) state_d = RD;
      RD:        state_d = RD_WAIT;
      RD_WAIT: begin
        if (drp_rdy)     state_d = WR;
        else if (drp_to) state_d = last_q ? HOLD : DRAIN;
      end
      WR:        state_d = WR_WAIT;
      WR_WAIT: begin
        if (drp_rdy)     state_d = last_q ? HOLD : ACCEPT;
        else if (drp_to) state_d = last_q ? HOLD : DRAIN;
      end
      ACCEPT:    if (hs) state_d = RD;
      DRAIN:     if (hs && cmd_last) state_d = HOLD;
      HOLD:      if (hold_end) state_d = LOCK_WAIT;
      LOCK_WAIT: if (fin) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      rdat_q   <= '0;
      wcnt_q   <= '0;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      sync_q   <= '0;
      mmcm_rst <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], mmcm_locked};
      if (hs) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        mask_q <= cmd_mask;
        last_q <= cmd_last;
      end
      if (state_q == RD_WAIT && drp_rdy)
        rdat_q <= drp_do;
      wcnt_q <= in_wait ? wcnt_q + 1'b1 : '0;
      hcnt_q <= (state_q == HOLD) ? hcnt_q + 1'b1 : '0;
      lcnt_q <= (state_q == LOCK_WAIT) ? lcnt_q + 1'b1 : '0;
      done   <= fin;
      if (state_q == IDLE && hs) begin
        busy     <= 1'b1;
        mmcm_rst <= 1'b1;
      end else begin
        if (fin) busy <= 1'b0;
        if (state_q == HOLD && hold_end) mmcm_rst <= 1'b0;
      end
      // a DRP timeout code is sticky over a later lock timeout
      if (state_q == IDLE && hs)
        err_code <= 2'd0;
      else if (in_wait && !drp_rdy && drp_to)
        err_code <= 2'd1;
      else if (fin && !lock_ok && err_code == 2'd0)
        err_code <= 2'd2;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: DRP slave model, lock model,
// access scoreboard, vector table plus corner-case sequences.
module tb_mmcm_drp_reconfig;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [15:0] cmd_mask = '0;
  logic        cmd_last = 1'b0;
  logic        cmd_ready;
  logic [6:0]  drp_addr;
  logic        drp_en, drp_we;
  logic [15:0] drp_di;
  logic        mmcm_rst, busy, done;
  logic [1:0]  err_code;
  bit          drp_rdy;
  bit [15:0]   drp_do;
  bit          mmcm_locked;

  mmcm_drp_reconfig #(
    .DRP_TIMEOUT(64), .RST_HOLD(HOLD), .LOCK_TIMEOUT(100)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_mask(cmd_mask), .cmd_last(cmd_last),
    .drp_addr(drp_addr), .drp_en(drp_en), .drp_we(drp_we),
    .drp_di(drp_di), .drp_do(drp_do), .drp_rdy(drp_rdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
    .busy(busy), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } acc_t;

  acc_t        sbq[$];
  logic [15:0] shadow[128];
  bit          lock_en = 1'b1;
  bit          hang_en = 1'b0;
  logic [6:0]  hang_addr = '0;

  function automatic logic [15:0] init_val(input logic [6:0] a);
    logic [15:0] k;
    k = {9'd0, a} - 16'd8;
    return 16'hA5A5 ^ (k * 16'h0101);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave: DRDY three cycles after DEN, optional hang on one read
  logic [15:0] mem[128];
  bit          mval[128];
  bit          pend, p_we;
  logic [6:0]  p_addr;
  logic [15:0] p_di;
  int          dly;

  always @(posedge clk) begin
    drp_rdy <= 1'b0;
    if (drp_en) begin
      p_we   <= drp_we;
      p_addr <= drp_addr;
      p_di   <= drp_di;
      if (!(hang_en && !drp_we && drp_addr == hang_addr)) begin
        pend <= 1'b1;
        dly  <= 2;
      end
    end else if (pend) begin
      if (dly == 1) begin
        pend    <= 1'b0;
        drp_rdy <= 1'b1;
        if (p_we) begin
          mem[p_addr]  <= p_di;
          mval[p_addr] <= 1'b1;
        end else begin
          drp_do <= mval[p_addr] ? mem[p_addr] : init_val(p_addr);
        end
      end else begin
        dly <= dly - 1;
      end
    end
  end

  int lk_cnt = 0;
  always @(posedge clk) begin
    if (mmcm_rst) begin
      lk_cnt      <= 0;
      mmcm_locked <= 1'b0;
    end else if (lock_en && !mmcm_locked) begin
      if (lk_cnt == 9) mmcm_locked <= 1'b1;
      else lk_cnt <= lk_cnt + 1;
    end
  end

  bit         prev_rst, prev_en;
  logic [1:0] prev_err = 2'd0;
  int fall_cyc = 0, hold_len = 0, rst_cnt = 0, rst_falls = 0;
  int hang_cyc = 0, err1_cyc = 0;

  always @(negedge clk) begin : mon
    acc_t e;
    prev_rst <= mmcm_rst;
    prev_en  <= drp_en;
    prev_err <= err_code;
    if (rstn && prev_rst && !mmcm_rst) begin
      fall_cyc  <= cyc;
      hold_len  <= rst_cnt;
      rst_falls <= rst_falls + 1;
    end
    if (drp_rdy) rst_cnt <= 0;
    else if (mmcm_rst) rst_cnt <= rst_cnt + 1;
    if (err_code == 2'd1 && prev_err != 2'd1) err1_cyc <= cyc;
    if (drp_en) begin
      chk("den_gap", 32'(prev_en), 0);
      chk("rst_in_access", 32'(mmcm_rst), 1);
      chk("ready_in_access", 32'(cmd_ready), 0);
      if (hang_en && !drp_we && drp_addr == hang_addr) hang_cyc <= cyc;
      if (sbq.size() == 0) begin
        chk("den_unexpected", 32'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        chk("den_we", 32'(drp_we), 32'(e.we));
        chk("den_addr", 32'(drp_addr), 32'(e.addr));
        if (e.we) chk("den_di", 32'(drp_di), 32'(e.di));
      end
    end
  end

  task automatic expect_cmd(input logic [6:0] a, input logic [15:0] d,
                            input logic [15:0] m, input bit rd_only);
    logic [15:0] nv;
    sbq.push_back({1'b0, a, 16'h0000});
    if (!rd_only) begin
      nv = (shadow[a] & m) | (d & ~m);
      sbq.push_back({1'b1, a, nv});
      shadow[a] = nv;
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [15:0] d,
                      input logic [15:0] m, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    cmd_last  = l;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_wait", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    chk("done_seen", 32'(done), 1);
    at = cyc;
  endtask

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] m;
    logic [15:0] di;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t, n, f0, early;
    tbl[0] = '{7'h08, 16'h1041, 16'hE000, 16'hB041};
    tbl[1] = '{7'h09, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[2] = '{7'h14, 16'h0000, 16'hFFFF, 16'hA9A9};
    tbl[3] = '{7'h4F, 16'h00FF, 16'hF0F0, 16'hE0EF};
    tbl[4] = '{7'h7F, 16'hAAAA, 16'h5555, 16'hFAFA};
    for (int i = 0; i < 128; i++) shadow[i] = init_val(7'(i));

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mmcm", 32'(mmcm_rst), 0);
    chk("rst_en", 32'(drp_en), 0);
    chk("rst_err", 32'(err_code), 0);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      sbq.push_back({1'b0, tbl[i].a, 16'h0000});
      sbq.push_back({1'b1, tbl[i].a, tbl[i].di});
      shadow[tbl[i].a] = tbl[i].di;
      send(tbl[i].a, tbl[i].d, tbl[i].m, 1'b1);
      wait_done(t);
      chk("tbl_err", 32'(err_code), 0);
      chk("tbl_busy", 32'(busy), 0);
      chk("tbl_hold", 32'(hold_len), HOLD);
      chk("tbl_lock_lat",
          32'(t - fall_cyc >= 10 && t - fall_cyc <= 16), 1);
      @(negedge clk);
      chk("tbl_done_pulse", 32'(done), 0);
      chk("tbl_sbq", 32'(sbq.size()), 0);
    end

    f0 = rst_falls;
    expect_cmd(7'h08, 16'h0000, 16'h00FF, 1'b0);
    send(7'h08, 16'h0000, 16'h00FF, 1'b0);
    repeat (5) @(negedge clk);
    expect_cmd(7'h09, 16'h1234, 16'hFF00, 1'b0);
    send(7'h09, 16'h1234, 16'hFF00, 1'b0);
    repeat (5) @(negedge clk);
    expect_cmd(7'h14, 16'h5555, 16'h0F0F, 1'b0);
    send(7'h14, 16'h5555, 16'h0F0F, 1'b1);
    wait_done(t);
    chk("burst_err", 32'(err_code), 0);
    chk("burst_rst_falls", 32'(rst_falls - f0), 1);
    chk("burst_hold", 32'(hold_len), HOLD);
    chk("burst_sbq", 32'(sbq.size()), 0);

    hang_en   = 1'b1;
    hang_addr = 7'h09;
    expect_cmd(7'h08, 16'hFFFF, 16'hF0F0, 1'b0);
    send(7'h08, 16'hFFFF, 16'hF0F0, 1'b0);
    repeat (5) @(negedge clk);
    expect_cmd(7'h09, 16'h0F0F, 16'h0000, 1'b1);
    send(7'h09, 16'h0F0F, 16'h0000, 1'b0);
    repeat (5) @(negedge clk);
    send(7'h14, 16'h1111, 16'h0000, 1'b1);
    wait_done(t);
    chk("to_err", 32'(err_code), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_lat",
        32'(err1_cyc - hang_cyc >= 64 && err1_cyc - hang_cyc <= 66), 1);
    chk("to_sbq", 32'(sbq.size()), 0);
    @(negedge clk);
    chk("to_err_held", 32'(err_code), 1);
    hang_en = 1'b0;

    lock_en = 1'b0;
    expect_cmd(7'h14, 16'h00F0, 16'hFF0F, 1'b0);
    send(7'h14, 16'h00F0, 16'hFF0F, 1'b1);
    wait_done(t);
    chk("lto_lat", 32'(t - fall_cyc), 100);
    chk("lto_err", 32'(err_code), 2);
    chk("lto_busy", 32'(busy), 0);

    expect_cmd(7'h4F, 16'h0001, 16'hFFFE, 1'b0);
    send(7'h4F, 16'h0001, 16'hFFFE, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mmcm_rst && n < 2000);
    chk("t6_lockwait", 32'(busy && !mmcm_rst), 1);
    cmd_valid = 1'b1;
    cmd_addr  = 7'h7F;
    cmd_data  = 16'h0000;
    cmd_mask  = 16'hFF00;
    cmd_last  = 1'b1;
    expect_cmd(7'h7F, 16'h0000, 16'hFF00, 1'b0);
    early = 0;
    n = 0;
    while (!done && n < 500) begin
      if (cmd_ready) early++;
      @(negedge clk);
      n++;
    end
    chk("t6_done", 32'(done), 1);
    chk("t6_no_early_hs", 32'(early), 0);
    chk("t6_err_prev", 32'(err_code), 2);
    chk("t6_ready_idle", 32'(cmd_ready), 1);
    lock_en = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", 32'(err_code), 0);
    chk("t6_busy", 32'(busy), 1);
    wait_done(t);
    chk("t6_err_end", 32'(err_code), 0);

    expect_cmd(7'h22, 16'hBEEF, 16'h0000, 1'b0);
    send(7'h22, 16'hBEEF, 16'h0000, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(drp_en && drp_we) && n < 500);
    chk("t5_wr_seen", 32'(drp_en && drp_we), 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t5_mmcm", 32'(mmcm_rst), 0);
    chk("t5_en", 32'(drp_en), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("t5_sbq", 32'(sbq.size()), 0);
    expect_cmd(7'h23, 16'hC0DE, 16'h00FF, 1'b0);
    send(7'h23, 16'hC0DE, 16'h00FF, 1'b1);
    wait_done(t);
    chk("t5_err", 32'(err_code), 0);
    chk("t5_sbq_end", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
